// File: rtl/add_serial_pkg.sv
// Shared definitions for the digit-serial adder-subtractor.
//   state_e       : FSM state encoding (code 3 is illegal and recovers to StIdle)
//   MinWidth      : smallest legal operand width
//   params_legal  : elaboration-time WIDTH/DIGIT legality check
package add_serial_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAdd  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam int unsigned MinWidth = 2;

  function automatic bit params_legal(input int unsigned width, input int unsigned digit);
    return (width >= MinWidth) && (digit >= 1) && (digit <= width) && ((width % digit) == 0);
  endfunction

endpackage

// File: rtl/add_serial_param_if.sv
// Operand/result bundle for add_serial_param.
//   en, sub, cin, a, b : requester -> adder
//   out, cout          : result and carry-out, valid while done=1
//   busy, done         : status
//   ovf                : signed overflow, only when ADD_SERIAL_OVF_EN is defined
// Modports: master (requester), slave (adder).
interface add_serial_param_if #(
  parameter int unsigned WIDTH = 8
);
  logic             en;
  logic             sub;
  logic             cin;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] out;
  logic             cout;
  logic             busy;
  logic             done;
`ifdef ADD_SERIAL_OVF_EN
  logic             ovf;

  modport master (output en, sub, cin, a, b, input out, cout, busy, done, ovf);
  modport slave  (input en, sub, cin, a, b, output out, cout, busy, done, ovf);
`else
  modport master (output en, sub, cin, a, b, input out, cout, busy, done);
  modport slave  (input en, sub, cin, a, b, output out, cout, busy, done);
`endif
endinterface

// File: rtl/add_serial_digit.sv
// Combinational DIGIT-bit adder slice.
//   a, b : digit operands
//   cin  : carry in
//   sum  : digit sum
//   cout : carry out of the digit
//   cmsb : carry into the digit's top bit (feeds signed-overflow detection)
module add_serial_digit #(
  parameter int unsigned DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  logic [DIGIT:0] full;

  assign full = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, cin};
  assign sum  = full[DIGIT-1:0];
  assign cout = full[DIGIT];
  // Sum bit = a ^ b ^ carry-in, so the carry into the top bit falls out directly.
  assign cmsb = full[DIGIT-1] ^ a[DIGIT-1] ^ b[DIGIT-1];

endmodule

// File: rtl/add_serial_param.sv
// Digit-serial adder-subtractor: adds (or subtracts) two WIDTH-bit operands DIGIT bits per
// cycle, least-significant digit first. Result ready WIDTH/DIGIT+1 cycles after en.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : add_serial_param_if slave (en/sub/cin/a/b in; out/cout/busy/done[/ovf] out)
// Optional feature: define ADD_SERIAL_OVF_EN to add the signed-overflow output ovf.
module add_serial_param
  import add_serial_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input logic              clk,
  input logic              rst,
  add_serial_param_if.slave bus
);

  localparam int unsigned N    = WIDTH / DIGIT;
  localparam int unsigned CntW = $clog2(N) + 1;

  if (!params_legal(WIDTH, DIGIT)) begin : g_bad_params
    $error("add_serial_param: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  state_e           state_q, state_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             carry_q, carry_d;

  logic [DIGIT-1:0] digit_sum;
  logic             digit_cout;
  logic             digit_cmsb;

  add_serial_digit #(
    .DIGIT (DIGIT)
  ) u_digit (
    .a    (a_q[DIGIT-1:0]),
    .b    (b_q[DIGIT-1:0]),
    .cin  (carry_q),
    .sum  (digit_sum),
    .cout (digit_cout),
    .cmsb (digit_cmsb)
  );

`ifdef ADD_SERIAL_OVF_EN
  logic cmsb_q, cmsb_d;
`else
  logic unused_cmsb;
  assign unused_cmsb = digit_cmsb;
`endif

  logic load;
  assign load = bus.en && ((state_q == StIdle) || (state_q == StDone));

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    a_d     = a_q;
    b_d     = b_q;
    out_d   = out_q;
    carry_d = carry_q;
`ifdef ADD_SERIAL_OVF_EN
    cmsb_d  = cmsb_q;
`endif
    case (state_q)
      StIdle, StDone: begin
        if (load) begin
          state_d = StAdd;
          count_d = '0;
          a_d     = bus.a;
          // Subtract as a + ~b + 1.
          b_d     = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub ? 1'b1 : bus.cin;
          out_d   = '0;
`ifdef ADD_SERIAL_OVF_EN
          cmsb_d  = 1'b0;
`endif
        end
      end
      StAdd: begin
        // New digit enters at the top; after N shifts digit 0 sits at the bottom.
        out_d   = (out_q >> DIGIT) | (WIDTH'(digit_sum) << (WIDTH - DIGIT));
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        carry_d = digit_cout;
        count_d = count_q + CntW'(1);
        if (count_q == CntW'(N - 1)) begin
          state_d = StDone;
`ifdef ADD_SERIAL_OVF_EN
          cmsb_d  = digit_cmsb;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      count_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      out_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      a_q     <= a_d;
      b_q     <= b_d;
      out_q   <= out_d;
      carry_q <= carry_d;
    end
  end

`ifdef ADD_SERIAL_OVF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmsb_q <= 1'b0;
    end else begin
      cmsb_q <= cmsb_d;
    end
  end

  assign bus.ovf = (state_q == StDone) && (carry_q ^ cmsb_q);
`endif

  assign bus.out  = out_q;
  assign bus.busy = (state_q == StAdd);
  assign bus.done = (state_q == StDone);
  // carry_q is mid-operation state outside DONE, so only expose it once the result is final.
  assign bus.cout = (state_q == StDone) && carry_q;

endmodule
